// File: rtl/ber_pkg.sv
// Shared types and defaults for the PRBS BER test controller.
package ber_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEASURE = 3'd2,
    DRAIN   = 3'd3
  } ber_state_t;

  localparam int unsigned CNT_W_DEF = 48;

endpackage

// File: rtl/ber_sat_accum.sv
// Saturating accumulator with a sticky saturation flag.
module ber_sat_accum #(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned OUT_W = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add_en,
  input  logic [IN_W-1:0]  add_val,
  output logic [OUT_W-1:0] sum,
  output logic             sat
);

  // One spare bit above the wider operand so the overflow test never wraps
  localparam int unsigned EXT_W = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
  localparam logic [EXT_W-1:0] MAX_EXT = {{(EXT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [EXT_W-1:0] total_c;
  logic             ovf_c;

  // Unclamped sum and overflow detect
  always_comb begin
    total_c = EXT_W'(sum) + EXT_W'(add_val);
    ovf_c   = (total_c > MAX_EXT);
  end

  // Accumulate, clamping at all-ones; clear has priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (clear) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (add_en) begin
      sum <= ovf_c ? '1 : OUT_W'(total_c);
      sat <= sat | ovf_c;
    end
  end

endmodule

// File: rtl/ber_test_ctrl.sv
// Sequences one PRBS BER test: arm, wait for lock, measure, report.
module ber_test_ctrl
  import ber_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      test_len,
  output logic             gen_en,
  output logic             chk_en,
  input  logic             chk_lock,
  input  logic [WIDTH:0]   chk_err_num,
  output logic             busy,
  output logic             done,
  output logic             lock_fail,
  output logic [CNT_W-1:0] bits_tested,
  output logic [CNT_W-1:0] err_total,
  output logic             err_sat,
  output logic [7:0]       relock_cnt
);

  localparam int unsigned ERR_W = WIDTH + 1;
  localparam int unsigned LEN_W = 32;
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

  ber_state_t       state, next_state;
  logic [TMO_W-1:0] tmo_q;
  logic [LEN_W-1:0] wcnt_q;
  logic [LEN_W-1:0] len_q;
  logic [ERR_W-1:0] err_q;

  logic accept_c, count_c, last_word_c, timeout_c, relock_c;
  logic gen_en_d, busy_d, done_d;
  logic bits_sat, errs_sat;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and per-cycle events; abort overrides everything
  always_comb begin
    next_state  = state;
    accept_c    = 1'b0;
    count_c     = 1'b0;
    timeout_c   = 1'b0;
    relock_c    = 1'b0;
    last_word_c = (len_q != '0) && ((wcnt_q + LEN_W'(1)) == len_q);
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept_c   = 1'b1;
          next_state = ARM;
        end
      end
      ARM: begin
        if (abort)                 next_state = IDLE;
        else if (chk_lock)         next_state = MEASURE;
        else if (tmo_q == TMO_LAST) begin
          timeout_c  = 1'b1;
          next_state = IDLE;
        end
      end
      MEASURE: begin
        if (abort) begin
          next_state = IDLE;
        end else if (chk_lock) begin
          count_c = 1'b1;
          if (last_word_c) next_state = DRAIN;
        end else begin
          relock_c   = 1'b1;
          next_state = ARM;
        end
      end
      DRAIN:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with it
  always_comb begin
    gen_en_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    gen_en_d = (next_state == ARM) || (next_state == MEASURE);
    busy_d   = (next_state != IDLE);
    done_d   = timeout_c || (next_state == DRAIN);
  end

  // Registered control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_en <= 1'b0;
      chk_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      gen_en <= gen_en_d;
      chk_en <= gen_en_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  // Timeout, word count, latched length, error pipeline and sticky status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q      <= '0;
      wcnt_q     <= '0;
      len_q      <= '0;
      err_q      <= '0;
      relock_cnt <= '0;
      lock_fail  <= 1'b0;
    end else begin
      tmo_q <= ((state == ARM) && (next_state == ARM)) ? tmo_q + TMO_W'(1) : '0;
      err_q <= count_c ? chk_err_num : '0;
      if (accept_c) begin
        wcnt_q     <= '0;
        len_q      <= test_len;
        relock_cnt <= '0;
        lock_fail  <= 1'b0;
      end else begin
        if (count_c) wcnt_q <= wcnt_q + LEN_W'(1);
        if (relock_c && (relock_cnt != 8'hFF)) relock_cnt <= relock_cnt + 8'd1;
        if (timeout_c) lock_fail <= 1'b1;
      end
    end
  end

  // Bits measured: WIDTH per locked word
  ber_sat_accum #(.IN_W(ERR_W), .OUT_W(CNT_W)) u_bits (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept_c),
    .add_en  (count_c),
    .add_val (ERR_W'(WIDTH)),
    .sum     (bits_tested),
    .sat     (bits_sat)
  );

  // Error total: err_q is zero on uncounted cycles, so adding while active is exact
  ber_sat_accum #(.IN_W(ERR_W), .OUT_W(CNT_W)) u_errs (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept_c),
    .add_en  (state != IDLE),
    .add_val (err_q),
    .sum     (err_total),
    .sat     (errs_sat)
  );

  assign err_sat = bits_sat | errs_sat;

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Bench for ber_test_ctrl: two widths driven in parallel against a word-level model.
module tb_ber_test_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned TMO   = 16;
  localparam int unsigned CW_A  = 48;
  localparam int unsigned CW_B  = 8;

  logic           clk = 1'b0;
  logic           reset, start, abort, chk_lock;
  logic [31:0]    test_len;
  logic [WIDTH:0] chk_err_num;

  logic            a_gen_en, a_chk_en, a_busy, a_done, a_lock_fail, a_err_sat;
  logic [CW_A-1:0] a_bits, a_err;
  logic [7:0]      a_relock;
  logic            b_gen_en, b_chk_en, b_busy, b_done, b_lock_fail, b_err_sat;
  logic [CW_B-1:0] b_bits, b_err;
  logic [7:0]      b_relock;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int en_cnt   = 0;

  always #5 clk = ~clk;

  ber_test_ctrl #(.WIDTH(WIDTH), .CNT_W(CW_A), .LOCK_TIMEOUT(TMO)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .test_len(test_len),
    .gen_en(a_gen_en), .chk_en(a_chk_en), .chk_lock(chk_lock), .chk_err_num(chk_err_num),
    .busy(a_busy), .done(a_done), .lock_fail(a_lock_fail), .bits_tested(a_bits),
    .err_total(a_err), .err_sat(a_err_sat), .relock_cnt(a_relock)
  );

  ber_test_ctrl #(.WIDTH(WIDTH), .CNT_W(CW_B), .LOCK_TIMEOUT(TMO)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .test_len(test_len),
    .gen_en(b_gen_en), .chk_en(b_chk_en), .chk_lock(chk_lock), .chk_err_num(chk_err_num),
    .busy(b_busy), .done(b_done), .lock_fail(b_lock_fail), .bits_tested(b_bits),
    .err_total(b_err), .err_sat(b_err_sat), .relock_cnt(b_relock)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint maxv(input int w);
    longint one;
    one = 1;
    return (one << w) - 1;
  endfunction

  function automatic longint clampw(input longint v, input int w);
    return (v > maxv(w)) ? maxv(w) : v;
  endfunction

  // Word-level model: phase, true (unclamped) totals, clamped only when compared
  int     m_phase;   // 0 idle, 1 waiting for lock, 2 measuring, 3 finishing
  int     m_wait;
  longint m_words, m_len, m_err_commit, m_err_pend;
  int     m_relock;
  bit     m_lock_fail, m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_wait = 0; m_words = 0; m_len = 0;
      m_err_commit = 0; m_err_pend = 0; m_relock = 0;
      m_lock_fail = 0; m_done = 0;
    end else begin
      m_done = 0;
      m_err_commit = m_err_commit + m_err_pend;
      m_err_pend = 0;
      if (m_phase == 0) begin
        if (start && !abort) begin
          m_words = 0; m_err_commit = 0; m_relock = 0; m_lock_fail = 0;
          m_len = 64'(test_len); m_phase = 1; m_wait = 0;
        end
      end else if (abort) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        m_wait++;
        if (chk_lock) m_phase = 2;
        else if (m_wait == TMO) begin
          m_phase = 0; m_lock_fail = 1; m_done = 1;
        end
      end else if (m_phase == 2) begin
        if (chk_lock) begin
          m_words++;
          m_err_pend = 64'(chk_err_num);
          if (m_len != 0 && m_words == m_len) begin
            m_phase = 3; m_done = 1;
          end
        end else begin
          if (m_relock < 255) m_relock++;
          m_phase = 1; m_wait = 0;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    longint tb;
    tb = m_words * WIDTH;
    chk("a_busy",   64'(a_busy),      64'(m_phase != 0));
    chk("a_gen_en", 64'(a_gen_en),    64'(m_phase == 1 || m_phase == 2));
    chk("a_chk_en", 64'(a_chk_en),    64'(m_phase == 1 || m_phase == 2));
    chk("a_done",   64'(a_done),      64'(m_done));
    chk("a_lockf",  64'(a_lock_fail), 64'(m_lock_fail));
    chk("a_relock", 64'(a_relock),    64'(m_relock));
    chk("a_bits",   64'(a_bits),      clampw(tb, CW_A));
    chk("a_err",    64'(a_err),       clampw(m_err_commit, CW_A));
    chk("a_sat",    64'(a_err_sat),   64'(tb > maxv(CW_A) || m_err_commit > maxv(CW_A)));
    chk("b_busy",   64'(b_busy),      64'(m_phase != 0));
    chk("b_gen_en", 64'(b_gen_en),    64'(m_phase == 1 || m_phase == 2));
    chk("b_done",   64'(b_done),      64'(m_done));
    chk("b_lockf",  64'(b_lock_fail), 64'(m_lock_fail));
    chk("b_relock", 64'(b_relock),    64'(m_relock));
    chk("b_bits",   64'(b_bits),      clampw(tb, CW_B));
    chk("b_err",    64'(b_err),       clampw(m_err_commit, CW_B));
    chk("b_sat",    64'(b_err_sat),   64'(tb > maxv(CW_B) || m_err_commit > maxv(CW_B)));
    if (a_done) done_cnt++;
    if (a_gen_en) en_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] len);
    done_cnt = 0;
    en_cnt   = 0;
    test_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int c;
    c = 0;
    while (a_busy && c < maxc) begin
      tick();
      c++;
    end
    n_checks++;
    if (a_busy) begin
      n_errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, maxc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; chk_lock = 1'b0;
    test_len = '0; chk_err_num = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(a_busy), 0);
    chk("rst_bits", 64'(a_bits), 0);
    chk("rst_gen",  64'(a_gen_en), 0);
    reset = 1'b0;
    tick();

    // 1: clean link, lock arrives a few cycles after start
    do_start(32'd100);
    tick(); tick();
    chk_lock = 1'b1;
    wait_idle(300, "t1");
    chk("t1_bits",   64'(a_bits), 800);
    chk("t1_err",    64'(a_err), 0);
    chk("t1_lockf",  64'(a_lock_fail), 0);
    chk("t1_relock", 64'(a_relock), 0);
    chk("t1_done",   64'(done_cnt), 1);
    chk("t1_bsat",   64'(b_err_sat), 1);

    // start together with abort in IDLE is dropped, results stay
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    chk("sa_busy", 64'(a_busy), 0);
    chk("sa_bits", 64'(a_bits), 800);

    // 2: lock never arrives
    chk_lock = 1'b0;
    do_start(32'd50);
    wait_idle(100, "t2");
    tick();
    chk("t2_lockf", 64'(a_lock_fail), 1);
    chk("t2_done",  64'(done_cnt), 1);
    chk("t2_arm",   64'(en_cnt), 16);
    chk("t2_bits",  64'(a_bits), 0);

    // 3: errors on five of twenty words; a stray start mid-test is ignored
    chk_lock = 1'b1;
    do_start(32'd20);
    for (int e = 1; e < 40 && a_busy; e++) begin
      chk_err_num = ((e - 1) % 4 == 2 && (e - 1) <= 18) ? (WIDTH+1)'(3) : '0;
      start = ((e - 1) == 7);
      tick();
    end
    start = 1'b0; chk_err_num = '0;
    tick();
    chk("t3_err",  64'(a_err), 15);
    chk("t3_bits", 64'(a_bits), 160);
    chk("t3_done", 64'(done_cnt), 1);

    // 4: abort after fifty words
    chk_err_num = (WIDTH+1)'(1);
    do_start(32'd100);
    repeat (51) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; chk_err_num = '0;
    chk("t4_busy", 64'(a_busy), 0);
    chk("t4_gen",  64'(a_gen_en), 0);
    repeat (5) tick();
    chk("t4_bits", 64'(a_bits), 400);
    chk("t4_err",  64'(a_err), 50);
    chk("t4_done", 64'(done_cnt), 0);

    // 5: heavy errors saturate the narrow instance
    chk_err_num = (WIDTH+1)'(8);
    do_start(32'd40);
    wait_idle(100, "t5");
    chk_err_num = '0;
    tick();
    chk("t5_berr", 64'(b_err), 255);
    chk("t5_bsat", 64'(b_err_sat), 1);
    chk("t5_aerr", 64'(a_err), 320);
    chk("t5_asat", 64'(a_err_sat), 0);

    // 6: lock loss mid-measure, then asynchronous reset mid-test
    chk_err_num = (WIDTH+1)'(2);
    do_start(32'd100);
    repeat (20) tick();
    chk_lock = 1'b0;
    repeat (2) tick();
    chk_lock = 1'b1;
    repeat (10) tick();
    chk("t6_relock", 64'(a_relock), 1);
    chk("t6_busy",   64'(a_busy), 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_r_gen",    64'(a_gen_en), 0);
    chk("t6_r_chk",    64'(a_chk_en), 0);
    chk("t6_r_busy",   64'(a_busy), 0);
    chk("t6_r_done",   64'(a_done), 0);
    chk("t6_r_relock", 64'(a_relock), 0);
    chk("t6_r_bits",   64'(a_bits), 0);
    chk("t6_r_err",    64'(a_err), 0);
    chk("t6_r_lockf",  64'(a_lock_fail), 0);
    chk("t6_r_sat",    64'(a_err_sat), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_err_num = '0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
